fp_add_pipe: RTL and testbench
==============================

Name: fp_add_pipe

Overview:
- Parametrised, 3-stage pipelined floating-point adder functional unit for the Tomasulo execution cluster.
- Successor to the combinational 32-bit adder: configurable exponent/mantissa widths, valid/ready handshake, reservation-station tag passthrough, and flush.
- Sits between the adder reservation station (issue side) and the CDB arbiter (result side).

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored mantissa (fraction) width in bits; word width W = 1+EXP_W+MAN_W.
- TAG_W, 4, reservation-station tag width carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; kills all in-flight operations.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  unit accepts the operand pair this cycle.
- in_a  in  W  operand A, IEEE-754-style packed.
- in_b  in  W  operand B.
- in_tag  in  TAG_W  tag of the issuing reservation station.
- out_valid  out  1  result presented.
- out_ready  in  1  CDB arbiter accepts the result.
- out_res  out  W  packed sum.
- out_tag  out  TAG_W  tag travelling with out_res.

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous and active-high.
- Reset values: out_valid=0, out_res=0, out_tag=0, all internal stage valid bits=0. in_ready=1 once reset deasserts.
- Pipeline stages:
  - S1 unpack/align: split fields; subnormal inputs are flushed to signed zero; exponent compare and swap so |A|>=|B|; right-shift the smaller mantissa by the exponent difference. The shift keeps guard and round bits plus a sticky bit (OR of all shifted-out bits). A shift >= MAN_W+3 leaves only sticky.
  - S2 add/sub: effective subtract when the signs differ; MAN_W+5-bit mantissa add/sub.
  - S3 normalise/pack: leading-zero count and left shift, or 1-bit right shift on carry-out. Round toward zero: truncate guard/round/sticky. Pack into the S3 output register, which drives out_*.
- Latency: an accepted op appears on out_valid exactly 3 cycles after acceptance when not stalled. Throughput is 1 op/cycle.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready. All stage registers hold while stall=1.
  - in_ready = !stall (combinational).
  - out_res and out_tag stay stable while out_valid && !out_ready.
  - Pipeline capacity is 3 ops.
- Special cases:
  - NaN in either input, or +Inf + -Inf, gives canonical qNaN: sign 0, exponent all ones, fraction MSB 1, other fraction bits 0.
  - Inf + finite gives that Inf; Inf + same-sign Inf gives Inf.
  - Exponent overflow after normalisation gives signed Inf.
  - Underflow below the minimum normal exponent gives signed zero (flush).
  - Exact zero result: x + (-x) gives +0; (-0) + (-0) gives -0; +0 + -0 gives +0.
- flush: clears all stage valid bits and out_valid on the next edge and overrides stall. An op presented in the flush cycle is not accepted (in_ready is gated to 0 while flush=1).
- reset asserted mid-operation: all in-flight ops are discarded immediately and asynchronously; no partial result is emitted.

Optional Feature:
- Macro FP_ADD_PIPE_SUB_EN.
- When defined:
  - Extra port in_sub (in, 1) is sampled with the operands.
  - in_sub=1 inverts the sign of in_b before S1 alignment, so the unit computes A-B.
  - in_sub is carried through the pipeline with the op.
- When undefined: the port is absent and the unit always adds.

Test Plan:
- Basic add, default params: a=0x3F800000 (1.0), b=0x40000000 (2.0), tag=5, out_ready=1. Expect out_res=0x40400000, out_tag=5, out_valid exactly 3 cycles after acceptance.
- Cancellation and truncation:
  - 0x3FC00000 + 0xBFC00000 -> 0x00000000.
  - 0x4B800000 + 0x3F800000 -> 0x4B800000 (truncated).
  - 0x4B800000 + 0xBF800000 -> 0x4B7FFFFF (sticky borrow).
- Specials:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - 0x00400000 (subnormal) + 0x00000000 -> 0x00000000.
- Backpressure: hold out_ready=0 and stream 4 back-to-back ops with tags 1..4.
  - in_ready must drop after 3 acceptances; out_res/out_tag stay stable.
  - Release out_ready: tags emerge 1,2,3,4 in order with correct sums and no loss or duplication.
- Flush and reset:
  - Flush with 3 ops in flight and out_ready=0: out_valid=0 next cycle, and a later op emerges alone after 3 cycles.
  - Assert reset mid-stream: out_valid drops without waiting for a clock edge.
- With FP_ADD_PIPE_SUB_EN: in_sub=1, a=0x40400000 (3.0), b=0x3F800000 (1.0) -> 0x40000000 (2.0).

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined round-toward-zero floating-point adder with valid/ready, tag and flush.
// Define FP_ADD_PIPE_SUB_EN to add the in_sub port (computes A-B when set).
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef FP_ADD_PIPE_SUB_EN
    input  logic                   in_sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_res,
    output logic [TAG_W-1:0]       out_tag
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int FW = MAN_W + 4;
    localparam int LZ_W = $clog2(FW + 1);
    localparam int XW = (EXP_W > LZ_W ? EXP_W : LZ_W) + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    logic stall, sub, sb_in, a_big, inf_a, inf_b, nan_in;
    logic [W-2:0] mag_a, mag_b, mag_big, mag_small;
    logic [EXP_W-1:0] d;
    int dc;
    logic [FW-1:0] m_big, m_small, sh, lost;

    logic s1_v, s1_sign, s1_sub, s1_zs, s1_sp;
    logic [EXP_W-1:0] s1_exp;
    logic [FW-1:0] s1_ma, s1_mb;
    logic [W-1:0] s1_spv;
    logic [TAG_W-1:0] s1_tag;

    logic s2_v, s2_sign, s2_zs, s2_sp;
    logic [EXP_W-1:0] s2_exp;
    logic [FW:0] s2_sum;
    logic [W-1:0] s2_spv;
    logic [TAG_W-1:0] s2_tag;

    logic [LZ_W-1:0] lz;
    logic [XW-1:0] ne;
    logic [MAN_W-1:0] frac;
    logic [W-1:0] res;

`ifdef FP_ADD_PIPE_SUB_EN
    assign sub = in_sub;
`else
    assign sub = 1'b0;
`endif

    assign stall = out_valid && !out_ready;
    assign in_ready = !stall && !flush;

    // S1: flush subnormals, order by magnitude, align the smaller operand with guard/round/sticky
    always_comb begin
        sb_in = in_b[W-1] ^ sub;
        mag_a = (in_a[W-2:MAN_W] == '0) ? '0 : in_a[W-2:0];
        mag_b = (in_b[W-2:MAN_W] == '0) ? '0 : in_b[W-2:0];
        a_big = mag_a >= mag_b;
        mag_big = a_big ? mag_a : mag_b;
        mag_small = a_big ? mag_b : mag_a;
        d = mag_big[W-2:MAN_W] - mag_small[W-2:MAN_W];
        dc = (int'(d) > FW) ? FW : int'(d);
        m_big = {|mag_big[W-2:MAN_W], mag_big[MAN_W-1:0], 3'b000};
        m_small = {|mag_small[W-2:MAN_W], mag_small[MAN_W-1:0], 3'b000};
        sh = m_small >> dc;
        lost = m_small << (FW - dc);
        inf_a = &in_a[W-2:MAN_W] && ~|in_a[MAN_W-1:0];
        inf_b = &in_b[W-2:MAN_W] && ~|in_b[MAN_W-1:0];
        nan_in = (&in_a[W-2:MAN_W] && |in_a[MAN_W-1:0]) || (&in_b[W-2:MAN_W] && |in_b[MAN_W-1:0])
               || (inf_a && inf_b && (in_a[W-1] != sb_in));
    end

    // S3: normalise, truncate, detect overflow/underflow, pack
    always_comb begin
        lz = LZ_W'(FW);
        for (int i = 0; i < FW; i++) if (s2_sum[i]) lz = LZ_W'(FW - 1 - i);
        ne = s2_sum[FW] ? XW'(s2_exp) + XW'(1) : XW'(s2_exp) - XW'(lz);
        frac = s2_sum[FW] ? s2_sum[FW-1:4] : MAN_W'((s2_sum[FW-1:0] << lz) >> 3);
        res = s2_sp ? s2_spv
            : (s2_sum == '0) ? {s2_zs, {(W-1){1'b0}}}
            : (!ne[XW-1] && ne >= XW'(EMAX)) ? {s2_sign, EMAX, {MAN_W{1'b0}}}
            : (ne[XW-1] || ne == '0) ? {s2_sign, {(W-1){1'b0}}}
            : {s2_sign, ne[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sign <= a_big ? in_a[W-1] : sb_in;
            s1_exp <= mag_big[W-2:MAN_W];
            s1_ma <= m_big;
            s1_mb <= {sh[FW-1:1], sh[0] | (|lost)};
            s1_sub <= in_a[W-1] ^ sb_in;
            s1_zs <= in_a[W-1] & sb_in;
            s1_sp <= nan_in || inf_a || inf_b;
            s1_spv <= nan_in ? QNAN : {inf_a ? in_a[W-1] : sb_in, EMAX, {MAN_W{1'b0}}};
            s1_tag <= in_tag;
            s2_sign <= s1_sign;
            s2_exp <= s1_exp;
            s2_sum <= s1_sub ? {1'b0, s1_ma} - {1'b0, s1_mb} : {1'b0, s1_ma} + {1'b0, s1_mb};
            s2_zs <= s1_zs;
            s2_sp <= s1_sp;
            s2_spv <= s1_spv;
            s2_tag <= s1_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            out_valid <= 1'b0;
            out_res <= '0;
            out_tag <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            s1_v <= in_valid;
            s2_v <= s1_v;
            out_valid <= s2_v;
            out_res <= res;
            out_tag <= s2_tag;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed and randomized checks of fp_add_pipe against an exact round-toward-zero model.
module tb_fp_add_pipe;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, in_sub = 1'b0;
    logic in_ready, out_valid;
    logic [31:0] in_a = '0, in_b = '0, out_res, want = '0, ra, rb, rt;
    logic [3:0] in_tag = '0, out_tag;
    int checks = 0, failures = 0, acc = 0, outs = 0, cyc_n = 0, a0, o0, k, ea, eb, dd;
    bit lat_chk = 1'b0;
    logic [35:0] exp_q[$];
    int cyc_q[$];

    logic [31:0] dir_a [14] = '{32'h3F800000, 32'h3FC00000, 32'h4B800000, 32'h4B800000, 32'h7F800000,
                                32'h7F7FFFFF, 32'h00400000, 32'h80000000, 32'h00000000, 32'h7F800001,
                                32'hFF800000, 32'h3F800000, 32'h00800001, 32'h3F800000};
    logic [31:0] dir_b [14] = '{32'h40000000, 32'hBFC00000, 32'h3F800000, 32'hBF800000, 32'hFF800000,
                                32'h7F7FFFFF, 32'h00000000, 32'h80000000, 32'h80000000, 32'h3F800000,
                                32'h3F800000, 32'h80800001, 32'h80800000, 32'hB3000000};
    logic [31:0] dir_w [14] = '{32'h40400000, 32'h00000000, 32'h4B800000, 32'h4B7FFFFF, 32'h7FC00000,
                                32'h7F800000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h7FC00000,
                                32'hFF800000, 32'h3F7FFFFF, 32'h00000000, 32'h3F7FFFFF};
    logic [31:0] bp_a [4] = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h41000000};
    logic [31:0] bp_b [4] = '{32'h40000000, 32'h3F800000, 32'h40800000, 32'hBF800000};
    logic [31:0] bp_w [4] = '{32'h40400000, 32'h40800000, 32'h41000000, 32'h40E00000};

    fp_add_pipe dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
`ifdef FP_ADD_PIPE_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Exact sum of the two real values, then truncated toward zero into binary32.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        int xa, xb, emin, p, e;
        logic signed [63:0] va, vb, s, m;
        xa = int'(a[30:23]);
        xb = int'(b[30:23]);
        if (xa == 255 || xb == 255) begin
            if ((xa == 255 && a[22:0] != 0) || (xb == 255 && b[22:0] != 0) || (xa == 255 && xb == 255 && a[31] != b[31]))
                return 32'h7FC00000;
            return (xa == 255) ? {a[31], 8'hFF, 23'h0} : {b[31], 8'hFF, 23'h0};
        end
        if (xa == 0 && xb == 0) return {a[31] & b[31], 31'h0};
        if (xa == 0) return b;
        if (xb == 0) return a;
        emin = (xa < xb) ? xa : xb;
        va = 64'({1'b1, a[22:0]}) << (xa - emin);
        vb = 64'({1'b1, b[22:0]}) << (xb - emin);
        s = (a[31] ? -va : va) + (b[31] ? -vb : vb);
        if (s == 0) return 32'h0;
        m = (s < 0) ? -s : s;
        p = 0;
        for (int i = 0; i < 63; i++) if (m[i]) p = i;
        e = emin + p - 23;
        if (e >= 255) return {s < 0, 8'hFF, 23'h0};
        if (e <= 0) return {s < 0, 31'h0};
        m = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
        return {s < 0, 8'(e), m[22:0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input logic [31:0] w);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_tag = t;
        want = w;
    endtask

    // One clock: log accepted ops into the scoreboard, check delivered results, step to just past the edge.
    task automatic cyc();
        logic [35:0] e;
        int c;
        @(negedge clk);
        if (in_valid && in_ready) begin
            exp_q.push_back({in_tag, want});
            cyc_q.push_back(cyc_n);
            acc++;
        end
        if (out_valid && out_ready) begin
            outs++;
            chk("out_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk("out_res", out_res, e[31:0]);
                chk("out_tag", out_tag, e[35:32]);
                if (lat_chk) chk("latency", cyc_n - c, 3);
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_tag", out_tag, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);

        lat_chk = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(dir_a[i], dir_b[i], 4'((i == 0) ? 5 : i), dir_w[i]);
            cyc();
        end
        in_valid = 1'b0;
        repeat (5) cyc();
        chk("dir_count", outs, 14);

`ifdef FP_ADD_PIPE_SUB_EN
        in_sub = 1'b1;
        drive(32'h40400000, 32'h3F800000, 4'h7, 32'h40000000);
        cyc();
        in_valid = 1'b0;
        in_sub = 1'b0;
        repeat (4) cyc();
        chk("sub_count", outs, 15);
`endif

        out_ready = 1'b0;
        lat_chk = 1'b0;
        a0 = acc;
        o0 = outs;
        for (int i = 0; i < 6; i++) begin
            k = acc - a0;
            if (k < 4) drive(bp_a[k], bp_b[k], 4'(k + 1), bp_w[k]);
            cyc();
        end
        chk("bp_accepted", acc - a0, 3);
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_res", out_res, 32'h40400000);
            chk("bp_hold_tag", out_tag, 1);
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (acc - a0 == 4) in_valid = 1'b0;
            cyc();
        end
        chk("bp_outputs", outs - o0, 4);
        chk("bp_drained", exp_q.size(), 0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h3F800000, 32'h3F800000, 4'(8 + i), 32'h40000000);
            cyc();
        end
        chk("fl_full", out_valid, 1);
        flush = 1'b1;
        drive(32'h40000000, 32'h40000000, 4'hC, 32'h40800000);
        #1 chk("fl_in_ready", in_ready, 0);
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        exp_q.delete();
        cyc_q.delete();
        out_ready = 1'b1;
        lat_chk = 1'b1;
        o0 = outs;
        drive(32'h40A00000, 32'h3F000000, 4'hD, 32'h40B00000);
        cyc();
        in_valid = 1'b0;
        repeat (6) cyc();
        chk("fl_single_out", outs - o0, 1);

        lat_chk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h3F800000, 32'h40000000, 4'(i + 1), 32'h40400000);
            cyc();
        end
        chk("rs_busy", out_valid, 1);
        #2 reset = 1'b1;
        #1 chk("rs_async_valid", out_valid, 0);
        chk("rs_async_tag", out_tag, 0);
        in_valid = 1'b0;
        exp_q.delete();
        cyc_q.delete();
        o0 = outs;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) cyc();
        chk("rs_no_output", outs - o0, 0);

        a0 = acc;
        o0 = outs;
        for (int i = 0; i < 600; i++) begin
            ea = $urandom_range(1, 254);
            dd = $urandom_range(0, 38);
            eb = (ea > dd) ? ea - dd : ea + dd;
            if ($urandom_range(0, 15) == 0) eb = 0;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) rb = {~ra[31], ra[30:0]};
            if ($urandom_range(0, 1) == 1) begin
                rt = ra;
                ra = rb;
                rb = rt;
            end
`ifdef FP_ADD_PIPE_SUB_EN
            in_sub = 1'($urandom);
`endif
            drive(ra, rb, 4'($urandom), ref_add(ra, rb ^ {in_sub, 31'h0}));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) cyc();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_count", outs - o0, acc - a0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
